sram_access_arbiter: RTL and testbench

Round-robin arbiter sharing the single external 18-bit × 16-bit SRAM port between the decompressor datapath blocks (upsampling/colour-space-conversion stage, IDCT fetch/store stage, UART image loader). It accepts one access per cycle from the granted requester, drives the registered SRAM address, data and write-enable, and routes returning read data to the requester that issued it via a latency-matched tag pipeline. A bounded lock lets a requester hold the port for a burst, such as a Y/U/V prefetch sequence, without starving the others.

---
 rtl/sram_access_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter for the shared external SRAM port.
// Grants one requester per cycle, registers the access onto the SRAM pins and
// steers returning read data back to its issuer through a tag pipeline.
// A requester may lock the port for a bounded burst.
module sram_access_arbiter #(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_LOCK     = 64
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [NUM_REQ-1:0]     Req,
   input  logic [NUM_REQ-1:0]     Req_lock,
   input  logic [NUM_REQ-1:0]     Req_we_n,
   input  logic [NUM_REQ*18-1:0]  Req_address,
   input  logic [NUM_REQ*16-1:0]  Req_write_data,
   output logic [NUM_REQ-1:0]     Grant,
   output logic [NUM_REQ-1:0]     Read_valid,
   output logic [15:0]            Read_data,
   output logic [17:0]            SRAM_address,
   output logic [15:0]            SRAM_write_data,
   output logic                   SRAM_we_n,
   input  logic [15:0]            SRAM_read_data
);

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ID_W   = (NUM_REQ > 2) ? 2 : 1;
   localparam int unsigned CNT_W  = $clog2(MAX_LOCK + 1);
   localparam int unsigned STAGES = READ_LATENCY + 1;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t              state;
   logic [ID_W-1:0]     owner;
   logic [CNT_W-1:0]    lock_cnt;
   logic [ID_W-1:0]     ptr;

   logic                tag_v  [STAGES];
   logic [ID_W-1:0]     tag_id [STAGES];

   logic [ID_W-1:0]     arb_start;
   logic [ID_W-1:0]     arb_win;
   logic                arb_found;
   int unsigned         idx;
   logic                hold_owner;
   logic                gnt_any;
   logic [ID_W-1:0]     gnt_id;

   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_we_n;

   // Successor of a requester index, wrapping at NUM_REQ-1.
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      if (id == ID_W'(NUM_REQ - 1)) begin
         return '0;
      end
      return id + ID_W'(1);
   endfunction

   // Arbitration: locked owner keeps the port while requesting, otherwise round-robin search.
   always_comb begin
      arb_start  = (state == ST_LOCKED) ? next_id(owner) : ptr;
      arb_found  = 1'b0;
      arb_win    = '0;
      idx        = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(arb_start) + k) % NUM_REQ;
         if (!arb_found && Req[ID_W'(idx)]) begin
            arb_found = 1'b1;
            arb_win   = ID_W'(idx);
         end
      end
      hold_owner = (state == ST_LOCKED) && Req[owner];
      gnt_any    = !Reset && (hold_owner || arb_found);
      gnt_id     = hold_owner ? owner : arb_win;
      Grant      = '0;
      if (gnt_any) begin
         Grant[gnt_id] = 1'b1;
      end
   end

   // Select the granted requester's address, data and write enable.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_we_n = 1'b1;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (gnt_id == ID_W'(k)) begin
            sel_addr = Req_address[k*ADDR_W +: ADDR_W];
            sel_data = Req_write_data[k*DATA_W +: DATA_W];
            sel_we_n = Req_we_n[k];
         end
      end
   end

   // Lock FSM, burst counter and round-robin pointer.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= ST_IDLE;
         owner    <= '0;
         lock_cnt <= '0;
         ptr      <= '0;
      end else if (gnt_any) begin
         ptr <= next_id(gnt_id);
         if (hold_owner) begin
            // Release on lock drop or when this grant is the last one allowed.
            if (!Req_lock[owner] || (lock_cnt == CNT_W'(MAX_LOCK - 1))) begin
               state    <= ST_IDLE;
               lock_cnt <= '0;
            end else begin
               lock_cnt <= lock_cnt + CNT_W'(1);
            end
         end else if (Req_lock[arb_win] && (MAX_LOCK > 1)) begin
            state    <= ST_LOCKED;
            owner    <= arb_win;
            lock_cnt <= CNT_W'(1);
         end else begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
         end
      end else begin
         // Owner dropped its request and nobody else is asking.
         state    <= ST_IDLE;
         lock_cnt <= '0;
      end
   end

   // Register the granted access onto the SRAM pins; idle cycles only deassert write.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
      end else if (gnt_any) begin
         SRAM_address    <= sel_addr;
         SRAM_write_data <= sel_data;
         SRAM_we_n       <= sel_we_n;
      end else begin
         SRAM_we_n       <= 1'b1;
      end
   end

   // Read tag pipeline, matched to the SRAM read latency plus the address register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            tag_v[s]  <= 1'b0;
            tag_id[s] <= '0;
         end
      end else begin
         tag_v[0]  <= gnt_any && sel_we_n;
         tag_id[0] <= gnt_id;
         for (int unsigned s = 1; s < STAGES; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   // Decode the exiting tag into the per-requester read strobe.
   always_comb begin
      Read_valid = '0;
      if (tag_v[STAGES-1]) begin
         Read_valid[tag_id[STAGES-1]] = 1'b1;
      end
   end

   assign Read_data = SRAM_read_data;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a per-cycle reference model pushes
// expected grants, SRAM pin states and read returns; a negedge monitor pops and compares.
module tb_sram_access_arbiter;

   localparam int N  = 3;
   localparam int RL = 2;
   localparam int ML = 4;

   logic              Clock = 1'b0;
   logic              Reset;
   logic [N-1:0]      Req, Req_lock, Req_we_n;
   logic [N*18-1:0]   Req_address;
   logic [N*16-1:0]   Req_write_data;
   logic [N-1:0]      Grant, Read_valid;
   logic [15:0]       Read_data;
   logic [17:0]       SRAM_address;
   logic [15:0]       SRAM_write_data;
   logic              SRAM_we_n;
   logic [15:0]       SRAM_read_data;

   always #5 Clock = ~Clock;

   sram_access_arbiter #(.NUM_REQ(N), .READ_LATENCY(RL), .MAX_LOCK(ML)) dut (
      .Clock(Clock), .Reset(Reset), .Req(Req), .Req_lock(Req_lock), .Req_we_n(Req_we_n),
      .Req_address(Req_address), .Req_write_data(Req_write_data), .Grant(Grant),
      .Read_valid(Read_valid), .Read_data(Read_data), .SRAM_address(SRAM_address),
      .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
   );

   // SRAM device emulation and the model's view of memory contents
   logic [15:0] sram_mem  [0:262143];
   logic [15:0] model_mem [0:262143];
   logic [15:0] rd_d [RL];

   function automatic logic [15:0] init_val(input int unsigned a);
      return 16'((a * 40503) ^ (a >> 5));
   endfunction

   always @(posedge Clock) begin
      if (SRAM_we_n === 1'b0) sram_mem[SRAM_address] <= SRAM_write_data;
      rd_d[0] <= sram_mem[SRAM_address];
      for (int k = 1; k < RL; k++) rd_d[k] <= rd_d[k-1];
   end
   assign SRAM_read_data = rd_d[RL-1];

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   // Scoreboard queues
   typedef struct { int due; logic [N-1:0] grant; } gexp_t;
   typedef struct { int due; logic we_n; logic [17:0] addr; logic [15:0] data; } pexp_t;
   typedef struct { int due; int id; logic [15:0] data; } rexp_t;
   gexp_t gq[$];
   pexp_t pq[$];
   rexp_t rq[$];

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Reference model state
   int          m_ptr = 0;
   int          m_owner = -1;
   int          m_cnt = 0;
   logic        e_we_n = 1'b1;
   logic [17:0] e_addr = '0;
   logic [15:0] e_data = '0;

   // Pending requests per requester
   logic        p_act  [N];
   logic        p_lock [N];
   logic        p_wn   [N];
   logic        p_rep  [N];
   logic [17:0] p_addr [N];
   logic [15:0] p_data [N];
   logic        rand_on = 1'b0;

   task automatic set_req(input int i, input logic wn, input logic [17:0] a, input logic [15:0] d,
                          input logic lk, input logic rep);
      p_act[i] = 1'b1; p_wn[i] = wn; p_addr[i] = a; p_data[i] = d; p_lock[i] = lk; p_rep[i] = rep;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         p_act[i] = 1'b0; p_lock[i] = 1'b0; p_rep[i] = 1'b0;
      end
   endtask

   function automatic logic [17:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 18'($urandom);
      return 18'($urandom_range(0, 31));
   endfunction

   // One clock cycle: drive inputs, predict outcome, queue expectations, advance.
   task automatic tick(input logic rst);
      logic [N-1:0] r, l, wn, eg;
      int g, start, c;
      gexp_t ge;
      pexp_t pe;
      rexp_t re;
      for (int i = 0; i < N; i++) begin
         r[i]  = p_act[i];
         l[i]  = p_act[i] & p_lock[i];
         wn[i] = p_wn[i];
         Req_address[i*18 +: 18]    = p_addr[i];
         Req_write_data[i*16 +: 16] = p_data[i];
      end
      Reset = rst; Req = r; Req_lock = l; Req_we_n = wn;
      g = -1;
      if (rst) begin
         m_ptr = 0; m_owner = -1; m_cnt = 0;
         while (rq.size() > 0 && rq[rq.size()-1].due > cyc) rq.pop_back();
      end else if (m_owner >= 0 && r[m_owner]) begin
         g = m_owner;
         m_cnt++;
         if (!l[g] || m_cnt == ML) m_owner = -1;
         m_ptr = (g + 1) % N;
      end else begin
         start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
         m_owner = -1;
         for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (g < 0 && r[c]) g = c;
         end
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (l[g]) begin m_owner = g; m_cnt = 1; end
         end
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      ge.due = cyc; ge.grant = eg; gq.push_back(ge);
      if (rst) begin
         e_we_n = 1'b1; e_addr = '0; e_data = '0;
      end else if (g >= 0) begin
         e_we_n = wn[g]; e_addr = p_addr[g]; e_data = p_data[g];
         if (!wn[g]) model_mem[e_addr] = e_data;
         else begin
            re.due = cyc + 1 + RL; re.id = g; re.data = model_mem[e_addr];
            rq.push_back(re);
         end
      end else begin
         e_we_n = 1'b1;
      end
      pe.due = cyc + 1; pe.we_n = e_we_n; pe.addr = e_addr; pe.data = e_data;
      pq.push_back(pe);
      if (g >= 0) begin
         if (p_rep[g] || (rand_on && p_lock[g] && $urandom_range(0, 3) != 0)) begin
            p_addr[g] = rand_on ? rand_addr() : p_addr[g] + 18'd1;
            p_data[g] = 16'($urandom);
         end else begin
            p_act[g] = 1'b0;
         end
      end
      @(posedge Clock);
      #1;
   endtask

   // Monitor: compare the DUT against whatever the model expects for this cycle.
   gexp_t mg;
   pexp_t mp;
   rexp_t mr;
   logic [N-1:0] m_oh;
   always @(negedge Clock) begin
      if (gq.size() > 0 && gq[0].due == cyc) begin
         mg = gq.pop_front();
         chk("grant", 32'(Grant), 32'(mg.grant));
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
         mp = pq.pop_front();
         chk("sram_we_n", 32'(SRAM_we_n), 32'(mp.we_n));
         chk("sram_address", 32'(SRAM_address), 32'(mp.addr));
         chk("sram_write_data", 32'(SRAM_write_data), 32'(mp.data));
      end
      if (Read_valid != '0) begin
         if (rq.size() > 0 && rq[0].due == cyc) begin
            mr = rq.pop_front();
            m_oh = '0; m_oh[mr.id] = 1'b1;
            chk("read_valid", 32'(Read_valid), 32'(m_oh));
            chk("read_data", 32'(Read_data), 32'(mr.data));
         end else begin
            chk("read_valid_unexpected", 32'(Read_valid), 32'(0));
         end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
         mr = rq.pop_front();
         m_oh = '0; m_oh[mr.id] = 1'b1;
         chk("read_valid_missing", 32'(Read_valid), 32'(m_oh));
      end
   end

   initial begin
      for (int a = 0; a < 262144; a++) begin
         sram_mem[a]  = init_val(a);
         model_mem[a] = init_val(a);
      end
      for (int k = 0; k < RL; k++) rd_d[k] = '0;
      for (int i = 0; i < N; i++) begin
         p_wn[i] = 1'b1; p_addr[i] = '0; p_data[i] = '0;
      end
      clear_reqs();
      Reset = 1'b1; Req = '0; Req_lock = '0; Req_we_n = '1;
      Req_address = '0; Req_write_data = '0;
      @(posedge Clock); #1;
      tick(1); tick(1);
      tick(0); tick(0);
      // single read from requester 1
      set_req(1, 1'b1, 18'd38400, 16'h0, 1'b0, 1'b0);
      repeat (5) tick(0);
      // write from requester 2, then read it back from requester 0
      set_req(2, 1'b0, 18'd146944, 16'hA5C3, 1'b0, 1'b0);
      repeat (4) tick(0);
      set_req(0, 1'b1, 18'd146944, 16'h0, 1'b0, 1'b0);
      repeat (5) tick(0);
      // round robin after reset, all three held
      tick(1);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 18'(100 + 10 * i), 16'h0, 1'b0, 1'b1);
      repeat (6) tick(0);
      clear_reqs();
      repeat (4) tick(0);
      // locked burst from requester 0 against requester 2
      tick(1);
      set_req(0, 1'b1, 18'd200, 16'h0, 1'b1, 1'b1);
      set_req(2, 1'b1, 18'd300, 16'h0, 1'b0, 1'b0);
      repeat (7) tick(0);
      clear_reqs();
      repeat (4) tick(0);
      // interleaved reads on consecutive cycles
      set_req(0, 1'b1, 18'd400, 16'h0, 1'b0, 1'b0);
      tick(0);
      set_req(1, 1'b1, 18'd401, 16'h0, 1'b0, 1'b0);
      repeat (5) tick(0);
      // reset right after a granted read
      set_req(0, 1'b1, 18'd500, 16'h0, 1'b0, 1'b0);
      tick(0);
      set_req(0, 1'b1, 18'd501, 16'h0, 1'b0, 1'b0);
      set_req(1, 1'b1, 18'd502, 16'h0, 1'b0, 1'b0);
      tick(1);
      repeat (6) tick(0);
      // randomized traffic with bursts and occasional reset
      rand_on = 1'b1;
      repeat (3000) begin
         for (int i = 0; i < N; i++) begin
            if (!p_act[i] && $urandom_range(0, 2) == 0)
               set_req(i, ($urandom_range(0, 2) != 0), rand_addr(), 16'($urandom),
                       ($urandom_range(0, 3) == 0), 1'b0);
            else if (p_act[i] && $urandom_range(0, 7) == 0)
               p_lock[i] = ~p_lock[i];
         end
         tick($urandom_range(0, 399) == 0);
      end
      rand_on = 1'b0;
      clear_reqs();
      repeat (8) tick(0);
      chk("reads_drained", 32'(rq.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
